// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM-stage load/store port.
// A request is accepted in IDLE. The pipeline is held with stall_o until the
// access completes after LATENCY cycles, and ack_o then pulses for one cycle.
// Optional byte-enabled stores are built when DMEM_BYTE_EN is defined.
module dmem_responder #(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
`ifdef DMEM_BYTE_EN
    input  logic [3:0]  be_i,
`endif
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        ack_o,
    output logic        err_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nxt;
    logic [3:0]      count, count_nxt;

    logic [31:0]     mem [DEPTH];

    // request captured at acceptance; later input changes are ignored
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic            rd_q, wr_q, err_q;
`ifdef DMEM_BYTE_EN
    logic [3:0]      be_q;
`endif

    logic            req, req_err;
    logic            complete;
    logic [AW-1:0]   acc_idx;
    logic [31:0]     acc_data;
    logic            acc_rd, acc_wr, acc_err;
    logic [3:0]      acc_be;

    // request decode and error classification of the live inputs
    always_comb begin
        req     = MemRead_i | MemWrite_i;
        req_err = (addr_i[1:0] != 2'b00)
                | (addr_i[31:2] >= 30'(DEPTH))
                | (MemRead_i & MemWrite_i);
    end

    // next-state, down-counter and handshake outputs
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        stall_o   = 1'b0;
        ack_o     = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    stall_o = 1'b1;
                    if (LATENCY == 1) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = BUSY;
                        count_nxt = 4'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                stall_o   = 1'b1;
                count_nxt = count - 4'd1;
                if (count == 4'd1) state_nxt = DONE;
            end
            DONE: begin
                ack_o     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        err_o = ack_o & err_q;
    end

    // With LATENCY=1 the access completes straight from IDLE, before the
    // captured copy exists, so the completing edge uses the live inputs then.
    always_comb begin
        complete = (state_nxt == DONE) & ~rst_i;
        if (state == IDLE) begin
            acc_idx  = addr_i[AW+1:2];
            acc_data = data_i;
            acc_rd   = MemRead_i;
            acc_wr   = MemWrite_i;
            acc_err  = req_err;
`ifdef DMEM_BYTE_EN
            acc_be   = be_i;
`else
            acc_be   = '1;
`endif
        end else begin
            acc_idx  = idx_q;
            acc_data = wdata_q;
            acc_rd   = rd_q;
            acc_wr   = wr_q;
            acc_err  = err_q;
`ifdef DMEM_BYTE_EN
            acc_be   = be_q;
`else
            acc_be   = '1;
`endif
        end
    end

    // state register, counter and request capture
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            count   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
`ifdef DMEM_BYTE_EN
            be_q    <= '0;
`endif
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (state == IDLE && req) begin
                idx_q   <= addr_i[AW+1:2];
                wdata_q <= data_i;
                rd_q    <= MemRead_i;
                wr_q    <= MemWrite_i;
                err_q   <= req_err;
`ifdef DMEM_BYTE_EN
                be_q    <= be_i;
`endif
            end
        end
    end

    // array write on the edge entering DONE; errored stores are dropped
    always_ff @(posedge clk_i) begin
        if (complete && acc_wr && !acc_err) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (acc_be[b]) mem[acc_idx][8*b +: 8] <= acc_data[8*b +: 8];
            end
        end
    end

    // load data register; only completing loads change it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o <= '0;
        end else if (complete && acc_rd) begin
            data_o <= acc_err ? '0 : mem[acc_idx];
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH=32, LATENCY=4) with a scoreboard
// of expected ack responses. Byte-enable steps are built with DMEM_BYTE_EN.
module tb_dmem_responder;

    localparam int DEPTH   = 32;
    localparam int LATENCY = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
`ifdef DMEM_BYTE_EN
    logic [3:0]  be = 4'hF;
`endif
    logic [31:0] data_o;
    logic        stall_o, ack_o, err_o;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          ack_a, ack_b;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .MemRead_i  (mem_read),
        .MemWrite_i (mem_write),
        .addr_i     (addr),
        .data_i     (wdata),
`ifdef DMEM_BYTE_EN
        .be_i       (be),
`endif
        .data_o     (data_o),
        .stall_o    (stall_o),
        .ack_o      (ack_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one request, follow it to its ack and compare against the
    // scoreboard entry pushed when it was driven.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic e_err, input logic [31:0] e_data,
                          output int ack_cyc);
        exp_t x;
        int   start;
        bit   got;
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = d;
        x.err  = e_err;
        x.data = e_data;
        sb.push_back(x);
        // still in the previous access's ack cycle: the request counts from the next one
        if (ack_o === 1'b1) begin
            @(posedge clk);
            #1;
        end
        #1;
        start = cyc;
        check({tag, "_stall_c0"}, 32'(stall_o), 32'd1);
        got = 1'b0;
        ack_cyc = -1;
        for (int k = 1; k <= LATENCY + 8; k++) begin
            @(posedge clk);
            #1;
            if (ack_o === 1'b1) begin
                got = 1'b1;
                ack_cyc = cyc;
                break;
            end
            check({tag, "_stall_busy"}, 32'(stall_o), 32'd1);
        end
        if (!got) begin
            check({tag, "_ack_timeout"}, 32'(ack_o), 32'd1);
            void'(sb.pop_front());
        end else begin
            x = sb.pop_front();
            check({tag, "_latency"}, 32'(ack_cyc - start), 32'(LATENCY));
            check({tag, "_stall_ack"}, 32'(stall_o), 32'd0);
            check({tag, "_err"}, 32'(err_o), 32'(x.err));
            check({tag, "_data"}, data_o, x.data);
        end
    endtask

    initial begin
        int ac;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_ack", 32'(ack_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_data", data_o, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // store then load, misaligned and out-of-range accesses
        access("st10", 0, 1, 32'h10, 32'hDEADBEEF, 0, 32'h0, ac);
        access("ld10", 1, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, ac);
        access("ld12", 1, 0, 32'h12, 32'h0, 1, 32'h0, ac);
        access("st11", 0, 1, 32'h11, 32'h12345678, 1, 32'h0, ac);
        access("ld10b", 1, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, ac);
        access("ld80", 1, 0, 32'h80, 32'h0, 1, 32'h0, ac);

        // highest word, then both MemRead and MemWrite high
        access("st7c", 0, 1, 32'h7C, 32'hCAFEF00D, 0, 32'h0, ac);
        access("ld7c", 1, 0, 32'h7C, 32'h0, 0, 32'hCAFEF00D, ac);
        access("st04", 0, 1, 32'h4, 32'hA5A5A5A5, 0, 32'hCAFEF00D, ac);
        access("both04", 1, 1, 32'h4, 32'h1, 1, 32'h0, ac);
        access("ld04", 1, 0, 32'h4, 32'h0, 0, 32'hA5A5A5A5, ac);
        access("st08", 0, 1, 32'h8, 32'h11111111, 0, 32'hA5A5A5A5, ac);

        // reset in cycle 2 of a store to 0x8
        @(posedge clk);
        #1;
        mem_read = 1'b0; mem_write = 1'b1; addr = 32'h8; wdata = 32'h22222222;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        mem_write = 1'b0;
        @(posedge clk);
        #1;
        check("abort_stall", 32'(stall_o), 32'd0);
        check("abort_ack", 32'(ack_o), 32'd0);
        check("abort_data", data_o, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < LATENCY + 2; k++) begin
            @(posedge clk);
            #1;
            check("abort_no_ack", 32'(ack_o), 32'd0);
        end
        access("ld08", 1, 0, 32'h8, 32'h0, 0, 32'h11111111, ac);

        // back-to-back stores with the request held through the ack cycle
        @(posedge clk);
        #1;
        access("b2b_st0", 0, 1, 32'h0, 32'd5, 0, 32'h11111111, ack_a);
        access("b2b_st4", 0, 1, 32'h4, 32'd7, 0, 32'h11111111, ack_b);
        check("b2b_spacing", 32'(ack_b - ack_a), 32'(LATENCY + 1));
        access("b2b_ld0", 1, 0, 32'h0, 32'h0, 0, 32'd5, ac);
        access("b2b_ld4", 1, 0, 32'h4, 32'h0, 0, 32'd7, ac);

`ifdef DMEM_BYTE_EN
        // partial and empty byte masks; loads ignore be_i
        be = 4'hF;
        access("be_full", 0, 1, 32'h20, 32'hFFFFFFFF, 0, 32'd7, ac);
        be = 4'b0101;
        access("be_0101", 0, 1, 32'h20, 32'h00000000, 0, 32'd7, ac);
        be = 4'b0000;
        access("be_none", 0, 1, 32'h20, 32'h12345678, 0, 32'd7, ac);
        access("be_ld", 1, 0, 32'h20, 32'h0, 0, 32'hFF00FF00, ac);
        be = 4'hF;
`endif

        mem_read = 1'b0;
        mem_write = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // absolute time bound
    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
